// File: rtl/mem_pkg.sv
// Shared types and defaults for the wait-state memory responder.
package mem_pkg;

    localparam int unsigned DATA_W             = 32;
    localparam int unsigned ADDR_W             = 32;
    localparam int unsigned CNT_W              = 4;
    localparam int unsigned DEFAULT_LATENCY    = 2;
    localparam int unsigned DEFAULT_DEPTH_LOG2 = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // Misaligned, beyond the array, or both operations at once.
    function automatic logic req_err(req_t r, int unsigned depth_log2);
        logic [ADDR_W-1:0] upper;
        upper = r.addr >> (depth_log2 + 2);
        return (r.addr[1:0] != 2'b00) || (upper != '0) || (r.rd && r.wr);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word array: synchronous write, registered read.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents survive reset by design.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory slave with a fixed number of wait states, error checking and a one-cycle ready pulse.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY    = DEFAULT_LATENCY,
    parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              MemReady,
    output logic              Busy,
    output logic              MemErr
);

    state_e           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    req_t             req_q, req_next;
    logic             ready_next, err_next;
    logic             enter_resp, bad_req;
    logic             arr_we, arr_re;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            req_q    <= '0;
            MemReady <= 1'b0;
            MemErr   <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            req_q    <= req_next;
            MemReady <= ready_next;
            MemErr   <= err_next;
        end
    end

    // Next state; array strobes fire on the edge that enters RESP.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_next   = req_q;
        ready_next = 1'b0;
        err_next   = 1'b0;
        arr_we     = 1'b0;
        arr_re     = 1'b0;

        case (state)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    req_next.rd    = MemRead;
                    req_next.wr    = MemWrite;
                    req_next.addr  = Address;
                    req_next.wdata = WriteData;
                    cnt_next       = CNT_W'(LATENCY);
                    state_next     = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Zero latency enters RESP straight from IDLE, so judge the request being latched.
        enter_resp = (state_next == RESP) && (state != RESP) && !reset;
        bad_req    = req_err(req_next, DEPTH_LOG2);
        ready_next = enter_resp;
        err_next   = enter_resp && bad_req;
        arr_we     = enter_resp && !bad_req && req_next.wr;
        arr_re     = enter_resp && !bad_req && req_next.rd;
    end

    assign Busy = (state != IDLE);

    mem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .reset(reset),
        .we   (arr_we),
        .re   (arr_re),
        .addr (req_next.addr[DEPTH_LOG2+1:2]),
        .wdata(req_next.wdata),
        .rdata(ReadData)
    );

endmodule
